// File: rtl/pwm_peripheral.sv
// 16-pin output driver with a shared, period-boundary-buffered PWM waveform.
// Optional PWM_PERIOD_TICK_EN adds a one-clk period_start pulse aligned with each new period.
module pwm_peripheral #(
  parameter int PRESCALE = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out
`ifdef PWM_PERIOD_TICK_EN
  ,
  output logic        period_start
`endif
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] r_presc_cnt;
  logic [7:0]    r_pwm_cnt;
  logic [7:0]    r_duty_sh;
  logic          w_tick;
  logic          w_boundary;
  logic          w_pwm_lvl;
  logic [15:0]   w_en_out;
  logic [15:0]   w_en_pwm;
  logic [15:0]   w_out_next;

  assign w_en_out   = {en_reg_out_15_8, en_reg_out_7_0};
  assign w_en_pwm   = {en_reg_pwm_15_8, en_reg_pwm_7_0};
  assign w_tick     = (r_presc_cnt == PRESC_LAST);
  assign w_boundary = w_tick && (r_pwm_cnt == 8'hFF);

  // Full scale is forced high so 0xFF means a true 100% with no one-step dip.
  assign w_pwm_lvl = (r_duty_sh == 8'hFF) || (r_pwm_cnt < r_duty_sh);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc_cnt <= '0;
    end else if (w_tick) begin
      r_presc_cnt <= '0;
    end else begin
      r_presc_cnt <= r_presc_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm_cnt <= 8'h00;
    end else if (w_tick) begin
      r_pwm_cnt <= r_pwm_cnt + 8'h01;
    end
  end

  // Duty is only taken at the period boundary, so mid-period writes never cut or stretch a pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_duty_sh <= 8'h00;
    end else if (w_boundary) begin
      r_duty_sh <= pwm_duty_cycle;
    end
  end

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_pin
      assign w_out_next[gi] = w_en_out[gi] && (!w_en_pwm[gi] || w_pwm_lvl);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= 16'h0000;
    end else begin
      out <= w_out_next;
    end
  end

`ifdef PWM_PERIOD_TICK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_start <= 1'b0;
    end else begin
      period_start <= w_boundary;
    end
  end
`endif

endmodule

// File: tb/tb_pwm_peripheral.sv
// Bench for pwm_peripheral: closed-form arithmetic model checked every cycle,
// directed waveform measurements with literal expectations, and a random phase.
module tb_pwm_peripheral;
  localparam int P   = 13;
  localparam int PER = 256 * P;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  eo_lo = 8'h00;
  logic [7:0]  eo_hi = 8'h00;
  logic [7:0]  ep_lo = 8'h00;
  logic [7:0]  ep_hi = 8'h00;
  logic [7:0]  duty  = 8'h00;
  logic [15:0] out;
`ifdef PWM_PERIOD_TICK_EN
  logic        period_start;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pwm_peripheral #(.PRESCALE(P)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_reg_out_7_0  (eo_lo),
    .en_reg_out_15_8 (eo_hi),
    .en_reg_pwm_7_0  (ep_lo),
    .en_reg_pwm_15_8 (ep_hi),
    .pwm_duty_cycle  (duty),
    .out             (out)
`ifdef PWM_PERIOD_TICK_EN
    ,
    .period_start    (period_start)
`endif
  );

  // Model: after n clock edges out of reset the counter step is n/P mod 256;
  // duty is captured at every edge where n is a multiple of the period.
  int          n       = 0;
  logic [7:0]  duty_m  = 8'h00;
  logic [15:0] exp_out = 16'h0000;
  logic        exp_ps  = 1'b0;
  logic        m_lvl;
  logic [15:0] m_eo, m_ep;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n       = 0;
      duty_m  = 8'h00;
      exp_out = 16'h0000;
      exp_ps  = 1'b0;
    end else begin
      m_lvl   = (duty_m == 8'hFF) || (((n / P) % 256) < int'(duty_m));
      m_eo    = {eo_hi, eo_lo};
      m_ep    = {ep_hi, ep_lo};
      exp_out = m_eo & (~m_ep | {16{m_lvl}});
      n       = n + 1;
      exp_ps  = ((n % PER) == 0);
      if (exp_ps) duty_m = duty;
    end
  end

  always @(negedge clk) begin
    total++;
    if (out !== exp_out) begin
      bad++;
      $display("FAIL model_out t=%0t got=%h want=%h", $time, out, exp_out);
    end
`ifdef PWM_PERIOD_TICK_EN
    total++;
    if (period_start !== exp_ps) begin
      bad++;
      $display("FAIL model_period_start t=%0t got=%b want=%b", $time, period_start, exp_ps);
    end
`endif
  end

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end else begin
      $display("ok   %s = %0d", name, got);
    end
  endtask

  // Wait for a low-to-high transition of out[0], sampled on falling edges.
  task automatic wait_rise(input string name, input int max_cyc);
    logic prev;
    bit   seen;
    prev = out[0];
    seen = 0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      if (!prev && out[0]) seen = 1;
      prev = out[0];
    end
    check(name, int'(seen), 1);
  endtask

  // Starting on a high sample, count the high run then the low run.
  task automatic measure(output int hi, output int lo);
    hi = 0;
    lo = 0;
    while (out[0] && hi < 2 * PER) begin hi++; @(negedge clk); end
    while (!out[0] && lo < 2 * PER) begin lo++; @(negedge clk); end
  endtask

  int hi, lo, cnt;

  initial begin
    // Test 1: enables set during reset have no effect until release.
    eo_lo = 8'hFF; eo_hi = 8'hFF;
    repeat (3) @(negedge clk);
    check("reset_out", int'(out), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("static_high_all", int'(out), 16'hFFFF);

    // Test 2: 50% duty on pin 0 after the first boundary.
    eo_lo = 8'h01; eo_hi = 8'h00; ep_lo = 8'h01; duty = 8'h80;
    wait_rise("t2_first_rise", PER + 20);
    measure(hi, lo);
    check("t2_high_clk", hi, 1664);
    check("t2_low_clk", lo, 1664);
    check("t2_upper_pins", int'(out[15:1]), 0);

    // Test 3: duty 0 is constant low; duty FF is constant high with no glitch.
    duty = 8'h00;
    repeat (PER + 5) @(negedge clk);
    cnt = 0;
    for (int i = 0; i < 3 * PER; i++) begin @(negedge clk); cnt += int'(out[0]); end
    check("t3_duty00_ones", cnt, 0);
    duty = 8'hFF;
    wait_rise("t3_ff_rise", PER + 20);
    cnt = 0;
    for (int i = 0; i < PER; i++) begin @(negedge clk); cnt += int'(!out[0]); end
    check("t3_dutyFF_zeros", cnt, 0);

    // Test 4: a mid-period duty write waits for the next boundary.
    duty = 8'h40;
    wait_rise("t4_rise", 2 * PER + 20);
    hi = 0;
    while (out[0] && hi < 2 * PER) begin
      hi++;
      if (hi == 416) duty = 8'hC0;
      @(negedge clk);
    end
    lo = 0;
    while (!out[0] && lo < 2 * PER) begin lo++; @(negedge clk); end
    check("t4_old_high", hi, 832);
    check("t4_old_low", lo, 2496);
    measure(hi, lo);
    check("t4_new_high", hi, 2496);
    check("t4_new_low", lo, 832);
`ifdef PWM_PERIOD_TICK_EN
    cnt = 0;
    for (int i = 0; i < PER; i++) begin @(negedge clk); cnt += int'(period_start); end
    check("t4_period_start_pulses", cnt, 1);
`endif

    // Test 5: dropping output enable kills a high PWM pin in one clk.
    duty = 8'h80; eo_lo = 8'h09; ep_lo = 8'h29;
    cnt = 0;
    for (int i = 0; i < 2 * PER && !out[3]; i++) begin @(negedge clk); cnt++; end
    check("t5_pin3_high", int'(out[3]), 1);
    eo_lo = 8'h01;
    @(negedge clk);
    check("t5_pin3_off", int'(out[3]), 0);
    check("t5_pin5_off", int'(out[5]), 0);

    // Test 6: asynchronous reset mid high phase, then a full dead period.
    for (int i = 0; i < 2 * PER && !out[0]; i++) @(negedge clk);
    check("t6_pin0_high", int'(out[0]), 1);
    #3 rst_n = 1'b0;
    #1 check("t6_async_reset_out", int'(out), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    lo = 0;
    @(negedge clk);
    while (!out[0] && lo < 2 * PER) begin lo++; @(negedge clk); end
    check("t6_dead_clk", lo, 3328);
    measure(hi, lo);
    check("t6_high_clk", hi, 1664);
    check("t6_low_clk", lo, 1664);

    // Random phase: sparse random register updates, checked by the model.
    for (int i = 0; i < 3 * PER; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 99) < 2) begin
        case ($urandom_range(0, 4))
          0: eo_lo = 8'($urandom);
          1: eo_hi = 8'($urandom);
          2: ep_lo = 8'($urandom);
          3: ep_hi = 8'($urandom);
          default: begin
            case ($urandom_range(0, 3))
              0: duty = 8'h00;
              1: duty = 8'hFF;
              default: duty = 8'($urandom);
            endcase
          end
        endcase
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pwm_peripheral.md
Name: pwm_peripheral

Overview:
Downstream consumer of the SPI register bank. It takes the five 8-bit control registers (output enables, PWM enables, duty cycle) and drives 16 physical output pins. Each pin is one of: static low, static high, or a shared PWM waveform. The PWM runs at about 3 kHz from a 10 MHz clk, and duty updates are glitch-free (applied only at period boundaries).

Parameters:
PRESCALE, 13, clk cycles per PWM counter step; must be ≥1. PWM period = 256*PRESCALE clk cycles (3328 by default, ≈3.0 kHz at 10 MHz).

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
en_reg_out_7_0  input  8  output enable, pins 7:0
en_reg_out_15_8  input  8  output enable, pins 15:8
en_reg_pwm_7_0  input  8  PWM select, pins 7:0
en_reg_pwm_15_8  input  8  PWM select, pins 15:8
pwm_duty_cycle  input  8  requested duty, in 1/256 steps; 0xFF = 100%
out  output  16  registered pin drive

Behaviour:
- Inputs are synchronous to clk; there are no synchronizers. en_out = {en_reg_out_15_8, en_reg_out_7_0} and en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0}.
- Prescaler presc_cnt:
  - Width max(1, $clog2(PRESCALE)).
  - Counts 0..PRESCALE-1 and wraps to 0.
  - tick = (presc_cnt == PRESCALE-1); it is high for 1 clk.
  - PRESCALE=1 gives tick every cycle.
- Period counter pwm_cnt:
  - 8-bit; increments on tick only and wraps 255→0.
  - boundary = tick && pwm_cnt==255.
- Duty shadow duty_sh (8-bit):
  - On boundary, duty_sh <= pwm_duty_cycle, so the new period starts with count 0 using the new value.
  - Changes to pwm_duty_cycle at any other time have no effect until the next boundary, which removes runt or extended pulses.
- PWM level:
  - pwm_lvl = 1 if duty_sh==0xFF, else (pwm_cnt < duty_sh).
  - duty 0x00 gives constant 0. duty N (1..0xFE) gives high for N*PRESCALE clk per period.
- Pin drive, per bit i, registered:
  - out[i] <= en_out[i] ? (en_pwm[i] ? pwm_lvl : 1) : 0.
  - en_out and en_pwm changes are visible on out 1 clk after being sampled, not aligned to the period.
  - All 16 PWM pins are in phase.
- Latency: pwm_cnt/duty_sh state appears on out one clk later.
- Reset (async assert, sync release):
  - presc_cnt=0, pwm_cnt=0, duty_sh=0x00, out=16'h0000.
  - After release, PWM pins stay low until the first boundary (one full period), then follow pwm_duty_cycle.
- Reset mid-period: out drops to 0 immediately, without waiting for clk, and all counting restarts from 0.
- Simultaneous boundary and duty write: the value sampled at the boundary clk edge is loaded.

Optional Feature:
Macro: PWM_PERIOD_TICK_EN.
- Defined: adds output port period_start (1 bit, reset 0). It is registered high for exactly 1 clk, in the cycle after boundary, i.e. aligned with the first out update of the new period.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
1. Reset, then en_out=0xFFFF, en_pwm=0x0000 → out=0x0000 during reset; out=0xFFFF 1 clk after the enables are sampled.
2. en_out=0x0001, en_pwm=0x0001, duty=0x80, PRESCALE=13 → after the first boundary, out[0] is high 1664 clk and low 1664 clk with period 3328; out[15:1]=0.
3. Same as 2 with duty=0x00 → out[0] constant 0 across 3 periods. Then duty=0xFF → out[0] constant 1 from the next boundary onward, with no low glitch.
4. duty=0x40 running, change to 0xC0 at pwm_cnt=0x20 → the current period keeps an 832-clk high time; the next period has a 2496-clk high time. With PWM_PERIOD_TICK_EN, period_start pulses once per 3328 clk.
5. PWM active on pin 3 while out[3] is high, clear en_out[3] → out[3]=0 within 1 clk. en_pwm[5]=1 with en_out[5]=0 → out[5] stays 0.
6. Assert rst_n mid-high-phase → out=0 asynchronously. After release with duty=0x80 → out stays 0 for 3328 clk, then a 50% waveform.
